temp_average_divider: RTL and testbench

//  Sequential averaging stage that sits directly upstream of the display/alert encoder.
//  On start_i it latches SENSORS temperature readings and an enable mask.
//  It sums the enabled readings, one per cycle, then divides the sum by the enabled count

---
 rtl/temp_average_divider_pkg.sv | 18 +
 rtl/temp_average_divider_if.sv | 30 +++
 rtl/temp_average_divider_seq_divider.sv | 71 +++++++
 rtl/temp_average_divider.sv | 145 ++++++++++++++
 tb/tb_temp_average_divider.sv | 181 ++++++++++++++++++
 5 files changed

// File: rtl/temp_average_divider_pkg.sv
// Shared types and defaults for the temperature averaging stage and its encoder.
package temp_average_divider_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StSum  = 2'd1,
    StDiv  = 2'd2,
    StDone = 2'd3
  } state_e;

  localparam int unsigned TEMP_W_DEF = 8;
  localparam int unsigned SUM_W_DEF  = 16;
  localparam int unsigned NR_W       = 8;
  // Alert limits consumed by the downstream display/alert encoder.
  localparam int unsigned ALERT_LOW  = 19;
  localparam int unsigned ALERT_HIGH = 26;

endpackage

// File: rtl/temp_average_divider_if.sv
// Request/result bundle between the averaging stage and its requester.
interface temp_average_divider_if
  import temp_average_divider_pkg::*;
#(
  parameter int unsigned SENSORS = 8,
  parameter int unsigned TEMP_W  = TEMP_W_DEF,
  parameter int unsigned SUM_W   = SUM_W_DEF
);

  logic                      start_i;
  logic [SENSORS*TEMP_W-1:0] sensors_data_i;
  logic [SENSORS-1:0]        sensors_en_i;
  logic [SUM_W-1:0]          temp_Q_o;
  logic [SUM_W-1:0]          temp_R_o;
  logic [NR_W-1:0]           active_sensors_nr_o;
  logic                      busy_o;
  logic                      done_o;
  logic                      div_by_zero_o;

  modport master (
    output start_i, sensors_data_i, sensors_en_i,
    input  temp_Q_o, temp_R_o, active_sensors_nr_o, busy_o, done_o, div_by_zero_o
  );

  modport slave (
    input  start_i, sensors_data_i, sensors_en_i,
    output temp_Q_o, temp_R_o, active_sensors_nr_o, busy_o, done_o, div_by_zero_o
  );

endinterface

// File: rtl/temp_average_divider_seq_divider.sv
// Restoring divider, one quotient bit per clock, SUM_W steps after the start edge.
module temp_average_divider_seq_divider
  import temp_average_divider_pkg::*;
#(
  parameter int unsigned SUM_W     = SUM_W_DEF,
  parameter int unsigned DIVISOR_W = NR_W
) (
  input  logic                 clk_i,
  input  logic                 rst_n_i,
  input  logic                 start_i,
  input  logic [SUM_W-1:0]     dividend_i,
  input  logic [DIVISOR_W-1:0] divisor_i,
  output logic                 done_o,
  output logic [SUM_W-1:0]     quotient_o,
  output logic [DIVISOR_W-1:0] remainder_o
);

  localparam int unsigned CNT_W = (SUM_W > 1) ? $clog2(SUM_W) : 1;
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(SUM_W - 1);

  logic                 r_busy;
  logic [CNT_W-1:0]     r_cnt;
  logic [SUM_W-1:0]     r_quo;
  logic [DIVISOR_W-1:0] r_rem;
  logic [DIVISOR_W-1:0] r_div;

  logic [DIVISOR_W:0]   w_shift;
  logic [DIVISOR_W-1:0] w_diff;
  logic [DIVISOR_W-1:0] w_rem_nxt;
  logic [SUM_W-1:0]     w_quo_nxt;
  logic                 w_ge;

  // Remainder stays below the divisor, so the trial difference fits in DIVISOR_W bits.
  always_comb begin
    w_shift   = {r_rem, r_quo[SUM_W-1]};
    w_ge      = (w_shift >= {1'b0, r_div});
    w_diff    = w_shift[DIVISOR_W-1:0] - r_div;
    w_rem_nxt = w_ge ? w_diff : w_shift[DIVISOR_W-1:0];
    w_quo_nxt = {r_quo[SUM_W-2:0], w_ge};
  end

  // Result is presented combinationally during the final step so the caller can
  // capture it on the same edge that completes the division.
  assign done_o      = r_busy && (r_cnt == LAST_STEP);
  assign quotient_o  = w_quo_nxt;
  assign remainder_o = w_rem_nxt;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_busy <= 1'b0;
      r_cnt  <= '0;
      r_quo  <= '0;
      r_rem  <= '0;
      r_div  <= '0;
    end else if (r_busy) begin
      r_quo <= w_quo_nxt;
      r_rem <= w_rem_nxt;
      r_cnt <= r_cnt + 1'b1;
      if (done_o) begin
        r_busy <= 1'b0;
      end
    end else if (start_i) begin
      r_busy <= 1'b1;
      r_cnt  <= '0;
      r_quo  <= dividend_i;
      r_rem  <= '0;
      r_div  <= divisor_i;
    end
  end

endmodule

// File: rtl/temp_average_divider.sv
// Averages the enabled sensor readings: serial sum, then sequential division by the count.
module temp_average_divider
  import temp_average_divider_pkg::*;
#(
  parameter int unsigned SENSORS = 8,
  parameter int unsigned TEMP_W  = TEMP_W_DEF,
  parameter int unsigned SUM_W   = SUM_W_DEF
) (
  input  logic                 clk_i,
  input  logic                 rst_n_i,
  temp_average_divider_if.slave bus
);

  localparam int unsigned CNT_W = (SENSORS > 1) ? $clog2(SENSORS) : 1;
  localparam logic [CNT_W-1:0] LAST_CH = CNT_W'(SENSORS - 1);

  state_e r_state;
  state_e w_state_nxt;

  logic [TEMP_W-1:0]  r_data [SENSORS];
  logic [SENSORS-1:0] r_en;
  logic [CNT_W-1:0]   r_cnt;
  logic [SUM_W-1:0]   r_acc;
  logic [SUM_W-1:0]   r_q;
  logic [SUM_W-1:0]   r_r;
  logic [NR_W-1:0]    r_nr;
  logic               r_dbz;

  logic [SUM_W-1:0]   w_addend;
  logic [SUM_W-1:0]   w_sum_nxt;
  logic [NR_W-1:0]    w_popcnt;
  logic               w_last;
  logic               w_div_start;
  logic               w_div_done;
  logic [SUM_W-1:0]   w_div_q;
  logic [NR_W-1:0]    w_div_r;
  logic               w_busy;
  logic               w_done;

  always_comb begin
    w_popcnt = '0;
    for (int i = 0; i < SENSORS; i++) begin
      w_popcnt = w_popcnt + NR_W'(r_en[i]);
    end
  end

  assign w_addend  = r_en[r_cnt] ? SUM_W'(r_data[r_cnt]) : '0;
  assign w_sum_nxt = r_acc + w_addend;
  assign w_last    = (r_cnt == LAST_CH);
  // Divider takes the final sum on the last SUM edge, so its first step is the first DIV edge.
  assign w_div_start = (r_state == StSum) && w_last && (w_popcnt != '0);

  temp_average_divider_seq_divider #(
    .SUM_W     (SUM_W),
    .DIVISOR_W (NR_W)
  ) u_seq_divider (
    .clk_i       (clk_i),
    .rst_n_i     (rst_n_i),
    .start_i     (w_div_start),
    .dividend_i  (w_sum_nxt),
    .divisor_i   (w_popcnt),
    .done_o      (w_div_done),
    .quotient_o  (w_div_q),
    .remainder_o (w_div_r)
  );

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      StIdle: if (bus.start_i) w_state_nxt = StSum;
      StSum:  if (w_last) w_state_nxt = (w_popcnt != '0) ? StDiv : StDone;
      StDiv:  if (w_div_done) w_state_nxt = StDone;
      StDone: w_state_nxt = StIdle;
      default: w_state_nxt = StIdle;
    endcase
  end

  always_comb begin
    w_busy = (r_state != StIdle);
    w_done = (r_state == StDone);
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      for (int i = 0; i < SENSORS; i++) begin
        r_data[i] <= '0;
      end
      r_en  <= '0;
      r_cnt <= '0;
      r_acc <= '0;
      r_q   <= '0;
      r_r   <= '0;
      r_nr  <= '0;
      r_dbz <= 1'b0;
    end else begin
      unique case (r_state)
        StIdle: begin
          if (bus.start_i) begin
            for (int i = 0; i < SENSORS; i++) begin
              r_data[i] <= bus.sensors_data_i[i*TEMP_W +: TEMP_W];
            end
            r_en  <= bus.sensors_en_i;
            r_cnt <= '0;
            r_acc <= '0;
          end
        end
        StSum: begin
          r_acc <= w_sum_nxt;
          r_cnt <= r_cnt + 1'b1;
          if (w_last && (w_popcnt == '0)) begin
            r_q   <= '0;
            r_r   <= '0;
            r_nr  <= '0;
            r_dbz <= 1'b1;
          end
        end
        StDiv: begin
          if (w_div_done) begin
            r_q   <= w_div_q;
            r_r   <= SUM_W'(w_div_r);
            r_nr  <= w_popcnt;
            r_dbz <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.temp_Q_o            = r_q;
  assign bus.temp_R_o            = r_r;
  assign bus.active_sensors_nr_o = r_nr;
  assign bus.div_by_zero_o       = r_dbz;
  assign bus.busy_o              = w_busy;
  assign bus.done_o              = w_done;

endmodule

// File: tb/tb_temp_average_divider.sv
// Directed and random runs of the averaging stage against an arithmetic reference.
module tb_temp_average_divider;

  localparam int unsigned SENSORS = 8;
  localparam int unsigned TEMP_W  = 8;
  localparam int unsigned SUM_W   = 16;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   n_tests = 0;
  int   n_fail  = 0;

  temp_average_divider_if #(
    .SENSORS (SENSORS),
    .TEMP_W  (TEMP_W),
    .SUM_W   (SUM_W)
  ) u_if ();

  temp_average_divider #(
    .SENSORS (SENSORS),
    .TEMP_W  (TEMP_W),
    .SUM_W   (SUM_W)
  ) u_dut (
    .clk_i   (clk),
    .rst_n_i (rst_n),
    .bus     (u_if)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_tests++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  task automatic check_outs(input string tag, input int unsigned q, input int unsigned r,
                            input int unsigned nr, input int unsigned dbz);
    check({tag, " Q"},   32'(u_if.temp_Q_o), q);
    check({tag, " R"},   32'(u_if.temp_R_o), r);
    check({tag, " nr"},  32'(u_if.active_sensors_nr_o), nr);
    check({tag, " dbz"}, 32'(u_if.div_by_zero_o), dbz);
  endtask

  // Full run: reference result from plain arithmetic, latency counted from the start edge.
  task automatic run(input string tag, input logic [63:0] data, input logic [7:0] mask,
                     input bit perturb);
    int unsigned sum, cnt, exp_lat, seen, eq, er;
    sum = 0;
    cnt = 0;
    for (int i = 0; i < 8; i++) begin
      if (mask[i]) begin
        sum += 32'(data[i*8 +: 8]);
        cnt++;
      end
    end
    exp_lat = (cnt != 0) ? SENSORS + SUM_W : SENSORS;
    eq = (cnt != 0) ? sum / cnt : 0;
    er = (cnt != 0) ? sum % cnt : 0;

    @(negedge clk);
    u_if.sensors_data_i = data;
    u_if.sensors_en_i   = mask;
    u_if.start_i        = 1'b1;
    @(posedge clk);
    #1;
    u_if.start_i        = 1'b0;
    u_if.sensors_data_i = {$urandom(), $urandom()};
    u_if.sensors_en_i   = 8'($urandom());
    seen = 0;
    for (int e = 1; e <= 40 && seen == 0; e++) begin
      @(posedge clk);
      #1;
      if (e == 1) check({tag, " busy"}, 32'(u_if.busy_o), 1);
      if (u_if.done_o) begin
        seen = e;
      end else if (perturb && (e == 2 || e == 11)) begin
        u_if.start_i        = 1'b1;
        u_if.sensors_data_i = {$urandom(), $urandom()};
        u_if.sensors_en_i   = 8'($urandom());
      end else begin
        u_if.start_i = 1'b0;
      end
    end
    u_if.start_i = 1'b0;
    check({tag, " latency"}, seen, exp_lat);
    check_outs(tag, eq, er, cnt, (cnt == 0) ? 1 : 0);
    @(posedge clk);
    #1;
    check({tag, " done pulse"}, 32'(u_if.done_o), 0);
    check({tag, " idle"}, 32'(u_if.busy_o), 0);
    check({tag, " hold Q"}, 32'(u_if.temp_Q_o), eq);
  endtask

  initial begin
    logic [63:0] d;
    logic [7:0]  m;
    int unsigned sel, dones;

    u_if.start_i        = 1'b0;
    u_if.sensors_data_i = '0;
    u_if.sensors_en_i   = '0;
    repeat (3) @(posedge clk);
    #1;
    check_outs("reset", 0, 0, 0, 0);
    check("reset busy", 32'(u_if.busy_o), 0);
    check("reset done", 32'(u_if.done_o), 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Case 1: readings 20..27, all enabled.
    for (int i = 0; i < 8; i++) d[i*8 +: 8] = 8'(20 + i);
    run("all8", d, 8'hFF, 1'b0);

    // Case 2: three channels enabled, rest hold 99.
    for (int i = 0; i < 8; i++) d[i*8 +: 8] = 8'd99;
    d[7:0]   = 8'd22;
    d[15:8]  = 8'd23;
    d[31:24] = 8'd25;
    run("mask0b", d, 8'b0000_1011, 1'b0);

    // Case 3: empty mask, then a valid run clears the divide-by-zero flag.
    run("zero", d, 8'h00, 1'b0);
    run("after zero", d, 8'b0000_1011, 1'b0);

    // Case 4: saturated readings.
    d = '0;
    d[63:56] = 8'd255;
    run("ch7 255", d, 8'h80, 1'b0);
    d = {8{8'd255}};
    run("all 255", d, 8'hFF, 1'b0);

    // Case 5: start pulses mid-run with changing data are ignored.
    for (int i = 0; i < 8; i++) d[i*8 +: 8] = 8'(20 + i);
    run("restart ignored", d, 8'hFF, 1'b1);

    // Case 6: reset during DIV abandons the run.
    @(negedge clk);
    u_if.sensors_data_i = {8'd99, 8'd98, 8'd97, 8'd96, 8'd95, 8'd94, 8'd93, 8'd92};
    u_if.sensors_en_i   = 8'hFF;
    u_if.start_i        = 1'b1;
    @(posedge clk);
    #1;
    u_if.start_i = 1'b0;
    repeat (14) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check_outs("mid reset", 0, 0, 0, 0);
    check("mid reset busy", 32'(u_if.busy_o), 0);
    dones = 0;
    repeat (3) begin
      @(posedge clk);
      #1;
      if (u_if.done_o) dones++;
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (30) begin
      @(posedge clk);
      #1;
      if (u_if.done_o) dones++;
    end
    check("no spurious done", dones, 0);
    run("rerun all8", d, 8'hFF, 1'b0);

    // Random runs, biased towards empty and full masks.
    for (int k = 0; k < 24; k++) begin
      d   = {$urandom(), $urandom()};
      sel = $urandom_range(0, 4);
      m   = (sel == 0) ? 8'h00 : (sel == 1) ? 8'hFF : 8'($urandom());
      run("random", d, m, k[0]);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
